// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 matrix keypad scanner: key codes, FSM states
// and the (row, column) to key decode.
package keypad_pkg;

  localparam logic [3:0] NOKEY = 4'd10;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] digit;
    logic       star;
    logic       hash;
  } key_t;

  // Rows 0..2 carry digits 1..9; row 3 is "* 0 #".
  function automatic key_t key_map(input logic [1:0] row, input logic [1:0] col);
    key_t k;
    k.digit = NOKEY;
    k.star  = 1'b0;
    k.hash  = 1'b0;
    if (row != 2'd3) begin
      if (col != 2'd3) k.digit = 4'(row) * 4'd3 + 4'(col) + 4'd1;
    end else begin
      case (col)
        2'd0:    k.star  = 1'b1;
        2'd1:    k.digit = 4'd0;
        2'd2:    k.hash  = 1'b1;
        default: k.digit = NOKEY;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, with a configurable
// reset value so idle-high buses come out of reset idle.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x3 keypad decoder with press/release debounce, producing
// key / time_button / alarm_button levels and a one-cycle new-press strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 256,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       time_button,
  output logic       alarm_button,
  output logic       key_strobe
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] cs;

  sync_2ff #(
    .WIDTH    (3),
    .RESET_VAL(3'b111)
  ) u_col_sync (
    .clk_i (clock),
    .rst_ni(reset),
    .d_i   (col_n),
    .q_o   (cs)
  );

  state_e           state_q;
  logic [1:0]       row_q;
  logic [3:0]       row_n_q;
  logic [DIV_W-1:0] div_q;
  logic [DEB_W-1:0] cnt_q;
  logic [2:0]       cap_q;
  logic [1:0]       cap_col_q;
  logic [3:0]       key_q;
  logic             time_q;
  logic             alarm_q;
  logic             strobe_q;

  logic       single_low;
  logic [1:0] col_idx;
  key_t       km;

  // Zero or several low columns both count as "no key".
  always_comb begin
    single_low = (cs == 3'b110) || (cs == 3'b101) || (cs == 3'b011);
    col_idx    = 2'd0;
    if (!cs[1]) col_idx = 2'd1;
    if (!cs[2]) col_idx = 2'd2;
    km = key_map(row_q, cap_col_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      row_n_q   <= 4'b1110;
      div_q     <= '0;
      cnt_q     <= '0;
      cap_q     <= 3'b111;
      cap_col_q <= 2'd0;
      key_q     <= NOKEY;
      time_q    <= 1'b0;
      alarm_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (single_low) begin
              state_q   <= DEBOUNCE;
              cap_q     <= cs;
              cap_col_q <= col_idx;
              cnt_q     <= '0;
            end else begin
              row_q   <= row_q + 2'd1;
              row_n_q <= {row_n_q[2:0], row_n_q[3]};
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        DEBOUNCE: begin
          if (cs == cap_q) begin
            if (cnt_q == DEB_LAST) begin
              state_q  <= HELD;
              key_q    <= km.digit;
              time_q   <= km.hash;
              alarm_q  <= km.star;
              strobe_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + DEB_W'(1);
            end
          end else begin
            state_q <= SCAN;
            row_q   <= row_q + 2'd1;
            row_n_q <= {row_n_q[2:0], row_n_q[3]};
            div_q   <= '0;
          end
        end
        HELD: begin
          if (cs != cap_q) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
          end
        end
        RELEASE: begin
          if (cs == 3'b111) begin
            if (cnt_q == DEB_LAST) begin
              state_q <= SCAN;
              row_q   <= row_q + 2'd1;
              row_n_q <= {row_n_q[2:0], row_n_q[3]};
              div_q   <= '0;
              key_q   <= NOKEY;
              time_q  <= 1'b0;
              alarm_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + DEB_W'(1);
            end
          end else if (cs == cap_q) begin
            // Key came back before the release settled: resume without a new strobe.
            state_q <= HELD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= '0;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign row_n        = row_n_q;
  assign key          = key_q;
  assign time_button  = time_q;
  assign alarm_button = alarm_q;
  assign key_strobe   = strobe_q;

endmodule
